alu_interface: RTL and testbench
================================

ALU_INTERFACE -- requirements
Module: alu_interface

Interface
REQ-001 Parameter N, default 8: operand/result width in bits; SHALL match the ALU's N.
REQ-002 Parameter TIMEOUT, default 1000: inactivity limit in clock cycles, range 2..65535.
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Rst_n  input  1  reset, asynchronous, active-low.
REQ-005 RxDone  input  1  one-cycle pulse; RxData holds a valid received byte.
REQ-006 RxData  input  N  received byte.
REQ-007 TxDone  input  1  one-cycle pulse; transmitter has finished the current byte.
REQ-008 AluResult  input  N  ALU Result, combinational from BusA/BusB/OpCode.
REQ-009 BusA  output  N  operand A to ALU (registered).
REQ-010 BusB  output  N  operand B to ALU (registered).
REQ-011 OpCode  output  6  ALU operation code (registered).
REQ-012 TxStart  output  1  one-cycle pulse requesting transmission of TxData.
REQ-013 TxData  output  N  byte to transmit (registered).
REQ-014 Busy  output  1  high in EXEC and WAIT_TX states.
REQ-015 Timeout  output  1  one-cycle pulse when a partial frame is aborted.

Function
REQ-016 States SHALL be GET_A, GET_B, GET_OP, EXEC, WAIT_TX; encoding is free.
REQ-017 GET_A: on RxDone, BusA <= RxData, go to GET_B; else stay.
REQ-018 GET_B: on RxDone, BusB <= RxData, go to GET_OP.
REQ-019 GET_OP: on RxDone, OpCode <= RxData[5:0] (upper bits discarded), go to EXEC.
REQ-020 EXEC lasts exactly one cycle: TxData <= AluResult, TxStart <= 1, go to WAIT_TX.
REQ-021 TxStart SHALL be high for exactly one cycle, the cycle after EXEC; latency from third RxDone edge to TxStart high = 2 edges.
REQ-022 WAIT_TX: on TxDone, go to GET_A; BusA/BusB/OpCode/TxData retain values.
REQ-023 RxDone in EXEC or WAIT_TX SHALL be ignored (byte dropped, no state change).
REQ-024 TxDone outside WAIT_TX SHALL be ignored; TxDone in the TxStart cycle SHALL be honoured (WAIT_TX already entered).
REQ-025 BusA/BusB/OpCode SHALL change only on their capturing RxDone edge; no glitch between frames.
REQ-026 Unknown OpCode SHALL be passed through unchanged; result is whatever the ALU returns.

Reset
REQ-027 Rst_n low SHALL immediately force state GET_A, BusA=0, BusB=0, OpCode=0, TxData=0, TxStart=0, Busy=0, Timeout=0, timeout counter=0.
REQ-028 Reset mid-frame or during WAIT_TX SHALL discard the partial frame; no TxStart is generated afterward.

Configuration
REQ-029 Macro ALU_INTERFACE_TIMEOUT_EN defined: a 16-bit counter SHALL clear on every RxDone and on entry to GET_B/GET_OP, increment each cycle in GET_B/GET_OP; on reaching TIMEOUT-1 with no RxDone, next edge returns to GET_A, pulses Timeout one cycle, clears counter; captured registers retain values.
REQ-030 Macro undefined: no counter is built, Timeout SHALL be tied 0, GET_B/GET_OP wait indefinitely.

Verification
REQ-031 Real ALU (N=8) attached: RxData 0x05,0x03,0x20 -> TxStart pulse 2 edges after third RxDone, TxData=0x08, Busy high until TxDone.
REQ-032 Bytes 0x0C,0x0A,0x22 (subtract) then TxDone, then 0xF0,0x0F,0x27 (nor) -> TxData 0x02, then 0x00; two TxStart pulses total.
REQ-033 Extra RxDone 0x55 during WAIT_TX -> ignored; next frame 0x01,0x01,0x20 gives TxData=0x02, BusA=0x01.
REQ-034 Rst_n low after two bytes, release, send 0x02,0x02,0x24 -> TxData=0x02, no TxStart from aborted frame.
REQ-035 With ALU_INTERFACE_TIMEOUT_EN, TIMEOUT=16: send one byte, idle 16 cycles -> Timeout pulse, state GET_A; then 0x07,0x01,0x26 -> TxData=0x06. Without macro, same idle -> Timeout stays 0, next byte goes to BusB.

Source files
------------

// File: rtl/alu_interface_if.sv
// Byte-stream / ALU side signals of alu_interface bundled as one interface.
// master: the sequencer (drives the ALU operands and the transmit request); slave: the environment.
interface alu_interface_if #(
  parameter int unsigned N = 8
) ();
  logic         rx_done;
  logic [N-1:0] rx_data;
  logic         tx_done;
  logic [N-1:0] alu_result;
  logic [N-1:0] bus_a;
  logic [N-1:0] bus_b;
  logic [5:0]   op_code;
  logic         tx_start;
  logic [N-1:0] tx_data;
  logic         busy;
  logic         timeout;

  modport master (
    input  rx_done, rx_data, tx_done, alu_result,
    output bus_a, bus_b, op_code, tx_start, tx_data, busy, timeout
  );

  modport slave (
    output rx_done, rx_data, tx_done, alu_result,
    input  bus_a, bus_b, op_code, tx_start, tx_data, busy, timeout
  );
endinterface

// File: rtl/alu_interface.sv
// Collects A, B and opcode bytes from a receiver, runs the ALU and hands the result to a transmitter.
// Define ALU_INTERFACE_TIMEOUT_EN to abort partial frames after TIMEOUT idle cycles.
module alu_interface #(
  parameter int unsigned N       = 8,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_interface_if.master bus
);

  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("TIMEOUT must lie in 2..65535");
  end

  typedef enum logic [2:0] {StGetA, StGetB, StGetOp, StExec, StWaitTx} state_e;

  state_e       state_q, state_d;
  logic [N-1:0] bus_a_q, bus_a_d;
  logic [N-1:0] bus_b_q, bus_b_d;
  logic [5:0]   op_code_q, op_code_d;
  logic [N-1:0] tx_data_q, tx_data_d;
  logic         tx_start_q, tx_start_d;
  logic         busy_q, busy_d;
  logic         timeout_q, timeout_d;

`ifdef ALU_INTERFACE_TIMEOUT_EN
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);
  logic [15:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d    = state_q;
    bus_a_d    = bus_a_q;
    bus_b_d    = bus_b_q;
    op_code_d  = op_code_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    timeout_d  = 1'b0;

    unique case (state_q)
      StGetA: begin
        if (bus.rx_done) begin
          bus_a_d = bus.rx_data;
          state_d = StGetB;
        end
      end
      StGetB: begin
        if (bus.rx_done) begin
          bus_b_d = bus.rx_data;
          state_d = StGetOp;
        end
      end
      StGetOp: begin
        if (bus.rx_done) begin
          op_code_d = bus.rx_data[5:0];
          state_d   = StExec;
        end
      end
      StExec: begin
        tx_data_d  = bus.alu_result;
        tx_start_d = 1'b1;
        state_d    = StWaitTx;
      end
      StWaitTx: begin
        if (bus.tx_done) state_d = StGetA;
      end
      default: state_d = StGetA;
    endcase

`ifdef ALU_INTERFACE_TIMEOUT_EN
    // Counter only runs while a frame is partially received; leaving GET_A always finds it at 0.
    cnt_d = '0;
    if ((state_q == StGetB || state_q == StGetOp) && !bus.rx_done) begin
      if (cnt_q == TimeoutLast) begin
        state_d   = StGetA;
        timeout_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
`endif

    busy_d = (state_d == StExec) || (state_d == StWaitTx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StGetA;
      bus_a_q    <= '0;
      bus_b_q    <= '0;
      op_code_q  <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
`ifdef ALU_INTERFACE_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      bus_a_q    <= bus_a_d;
      bus_b_q    <= bus_b_d;
      op_code_q  <= op_code_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
`ifdef ALU_INTERFACE_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign bus.bus_a    = bus_a_q;
  assign bus.bus_b    = bus_b_q;
  assign bus.op_code  = op_code_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = tx_start_q;
  assign bus.busy     = busy_q;
  assign bus.timeout  = timeout_q;

endmodule

// File: tb/tb_alu_interface.sv
// Bench for alu_interface: directed frames against a small MIPS-funct ALU model, results
// checked by a scoreboard monitor on every tx_start pulse.
module tb_alu_interface;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   pulses;
  int   exp_pulses;
  logic prev_start;
  logic [7:0] exp_q[$];
  logic [7:0] alu_r;

  alu_interface_if #(.N(8)) bus ();

  alu_interface #(
    .N      (8),
    .TIMEOUT(16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU; unknown codes return a fixed marker value.
  always_comb begin
    case (bus.op_code)
      6'h20:   alu_r = bus.bus_a + bus.bus_b;
      6'h22:   alu_r = bus.bus_a - bus.bus_b;
      6'h24:   alu_r = bus.bus_a & bus.bus_b;
      6'h25:   alu_r = bus.bus_a | bus.bus_b;
      6'h26:   alu_r = bus.bus_a ^ bus.bus_b;
      6'h27:   alu_r = ~(bus.bus_a | bus.bus_b);
      default: alu_r = 8'hA5;
    endcase
  end
  assign bus.alu_result = alu_r;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && bus.tx_start) begin
      pulses++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_tx_start: got tx_data %02h expected no pulse at %0t",
                 bus.tx_data, $time);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (bus.tx_data !== e) begin
          errors++;
          $display("FAIL tx_data: got %02h expected %02h at %0t", bus.tx_data, e, $time);
        end
      end
      if (prev_start) begin
        errors++;
        $display("FAIL tx_start_width: got 2+ cycles expected 1 at %0t", $time);
      end
    end
    prev_start = rst_n && bus.tx_start;
  end

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    @(negedge clk);
    bus.rx_done = 1'b0;
  endtask

  task automatic pulse_tx_done();
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
  endtask

  // mode 0: tx_done later; 1: tx_done in the tx_start cycle; 2: stray byte during WAIT_TX
  task automatic finish_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                              input logic [7:0] exp, input int mode);
    exp_q.push_back(exp);
    exp_pulses++;
    send_byte(op);
    check("exec_busy", 8'(bus.busy), 8'h01);
    check("exec_no_start", 8'(bus.tx_start), 8'h00);
    @(negedge clk);
    check("tx_start_latency", 8'(bus.tx_start), 8'h01);
    check("op_code", 8'(bus.op_code), {2'b00, op[5:0]});
    check("bus_a", bus.bus_a, a);
    check("bus_b", bus.bus_b, b);
    if (mode == 1) begin
      pulse_tx_done();
    end else begin
      if (mode == 2) begin
        send_byte(8'h55);
        check("stray_bus_a", bus.bus_a, a);
        check("stray_bus_b", bus.bus_b, b);
      end else begin
        @(negedge clk);
      end
      check("wait_busy", 8'(bus.busy), 8'h01);
      check("wait_tx_data", bus.tx_data, exp);
      pulse_tx_done();
    end
    check("idle_after_done", 8'(bus.busy), 8'h00);
  endtask

  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                           input logic [7:0] exp, input int mode);
    send_byte(a);
    send_byte(b);
    finish_frame(a, b, op, exp, mode);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    pulses      = 0;
    exp_pulses  = 0;
    prev_start  = 1'b0;
    bus.rx_done = 1'b0;
    bus.rx_data = 8'h00;
    bus.tx_done = 1'b0;
    rst_n       = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_bus_a", bus.bus_a, 8'h00);
    check("rst_bus_b", bus.bus_b, 8'h00);
    check("rst_op_code", 8'(bus.op_code), 8'h00);
    check("rst_tx_data", bus.tx_data, 8'h00);
    check("rst_ctrl", {5'b0, bus.tx_start, bus.busy, bus.timeout}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_frame(8'h05, 8'h03, 8'h20, 8'h08, 0);
    run_frame(8'h0C, 8'h0A, 8'h22, 8'h02, 0);
    run_frame(8'hF0, 8'h0F, 8'h27, 8'h00, 1);
    run_frame(8'h10, 8'h20, 8'h25, 8'h30, 2);
    // tx_done while collecting bytes must be ignored
    pulse_tx_done();
    send_byte(8'h01);
    pulse_tx_done();
    send_byte(8'h01);
    finish_frame(8'h01, 8'h01, 8'h20, 8'h02, 0);
    // Unknown opcode, upper bits of the opcode byte dropped
    run_frame(8'h11, 8'h22, 8'hFF, 8'hA5, 0);

    // Reset mid-frame
    send_byte(8'h09);
    send_byte(8'h09);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_bus_a", bus.bus_a, 8'h00);
    check("midrst_bus_b", bus.bus_b, 8'h00);
    check("midrst_tx_data", bus.tx_data, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("midrst_idle", {6'b0, bus.busy, bus.tx_start}, 8'h00);
    run_frame(8'h02, 8'h02, 8'h24, 8'h02, 0);

`ifdef ALU_INTERFACE_TIMEOUT_EN
    begin
      int n;
      n = 0;
      send_byte(8'h03);
      while (n < 40 && bus.timeout !== 1'b1) begin
        @(negedge clk);
        n++;
      end
      check("timeout_cycles", 8'(n), 8'd16);
      check("timeout_bus_a", bus.bus_a, 8'h03);
      @(negedge clk);
      check("timeout_pulse_width", 8'(bus.timeout), 8'h00);
      check("timeout_busy", 8'(bus.busy), 8'h00);
      run_frame(8'h07, 8'h01, 8'h26, 8'h06, 0);
    end
`else
    begin
      logic seen;
      seen = 1'b0;
      send_byte(8'h03);
      repeat (20) begin
        @(negedge clk);
        if (bus.timeout !== 1'b0) seen = 1'b1;
      end
      check("no_timeout", 8'(seen), 8'h00);
      send_byte(8'h01);
      check("late_bus_b", bus.bus_b, 8'h01);
      check("late_bus_a", bus.bus_a, 8'h03);
      finish_frame(8'h03, 8'h01, 8'h26, 8'h02, 0);
    end
`endif

    repeat (4) @(negedge clk);
    check("pulse_count", 8'(pulses), 8'(exp_pulses));
    check("queue_empty", 8'(exp_q.size()), 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
